vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Two-requester SRAM arbiter: display has priority during the visible region,
// with a starvation counter that eventually forces a CPU grant.
module vram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_active,
    input  logic        disp_req,
    input  logic [17:0] disp_addr,
    output logic [15:0] disp_rdata,
    output logic        disp_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_din,
    output logic [15:0] sram_dout,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, DISP_RD, CPU_RD, CPU_WR} state_t;

    localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WAIT_MAX = 4'(STARVE_LIMIT);

    state_t      state_r, nextState_s;
    logic [2:0]  cnt_r;
    logic [3:0]  cpuWait_r;
    logic        dispPend_r, cpuPend_r, cpuWe_r;
    logic [17:0] dispAddr_r, cpuAddr_r;
    logic [15:0] cpuWdata_r;
    logic        grantDisp_s, grantCpu_s, lastCycle_s;
    logic        dispAccept_s, cpuAccept_s;

    // Arbitration, next state and request acceptance
    always_comb begin
        nextState_s  = state_r;
        grantDisp_s  = 1'b0;
        grantCpu_s   = 1'b0;
        lastCycle_s  = (state_r != IDLE) && (cnt_r == LAST_CNT);
        // A requester in service cannot queue a second access behind itself.
        dispAccept_s = disp_req && !dispPend_r && (state_r != DISP_RD);
        cpuAccept_s  = cpu_req && !cpuPend_r && (state_r != CPU_RD) && (state_r != CPU_WR);
        case (state_r)
            IDLE: begin
                if (dispPend_r && (!cpuPend_r || (disp_active && (cpuWait_r != WAIT_MAX)))) begin
                    grantDisp_s = 1'b1;
                    nextState_s = DISP_RD;
                end else if (cpuPend_r) begin
                    grantCpu_s  = 1'b1;
                    nextState_s = cpuWe_r ? CPU_WR : CPU_RD;
                end else begin
                    nextState_s = IDLE;
                end
            end
            DISP_RD, CPU_RD, CPU_WR: begin
                if (lastCycle_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = state_r;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // State register and access-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= nextState_s;
            if ((state_r == IDLE) || lastCycle_s) begin
                cnt_r <= 3'd0;
            end else begin
                cnt_r <= cnt_r + 3'd1;
            end
        end
    end

    // Pending flags and captured request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dispPend_r <= 1'b0;
            cpuPend_r  <= 1'b0;
            dispAddr_r <= 18'd0;
            cpuAddr_r  <= 18'd0;
            cpuWe_r    <= 1'b0;
            cpuWdata_r <= 16'd0;
        end else begin
            if (dispAccept_s) begin
                dispPend_r <= 1'b1;
                dispAddr_r <= disp_addr;
            end else if (grantDisp_s) begin
                dispPend_r <= 1'b0;
            end
            if (cpuAccept_s) begin
                cpuPend_r  <= 1'b1;
                cpuAddr_r  <= cpu_addr;
                cpuWe_r    <= cpu_we;
                cpuWdata_r <= cpu_wdata;
            end else if (grantCpu_s) begin
                cpuPend_r <= 1'b0;
            end
        end
    end

    // Starvation counter: display grants that overtook a waiting CPU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpuWait_r <= 4'd0;
        end else if (grantCpu_s) begin
            cpuWait_r <= 4'd0;
        end else if (grantDisp_s && cpuPend_r && (cpuWait_r != WAIT_MAX)) begin
            cpuWait_r <= cpuWait_r + 4'd1;
        end
    end

    // SRAM strobes and address registered from the next state so they never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_addr  <= 18'd0;
            sram_dout  <= 16'd0;
        end else begin
            sram_ce_n  <= (nextState_s == IDLE);
            sram_oe_n  <= !((nextState_s == DISP_RD) || (nextState_s == CPU_RD));
            sram_we_n  <= (nextState_s != CPU_WR);
            sram_dq_oe <= (nextState_s == CPU_WR);
            if (grantDisp_s) begin
                sram_addr <= dispAddr_r;
            end else if (grantCpu_s) begin
                sram_addr <= cpuAddr_r;
                sram_dout <= cpuWdata_r;
            end
        end
    end

    // Completion pulses and read-data capture at the end of the final access cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_valid <= 1'b0;
            cpu_done   <= 1'b0;
            disp_rdata <= 16'd0;
            cpu_rdata  <= 16'd0;
        end else begin
            disp_valid <= lastCycle_s && (state_r == DISP_RD);
            cpu_done   <= lastCycle_s && ((state_r == CPU_RD) || (state_r == CPU_WR));
            if (lastCycle_s && (state_r == DISP_RD)) begin
                disp_rdata <= sram_din;
            end
            if (lastCycle_s && (state_r == CPU_RD)) begin
                cpu_rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: random traffic against a timestamp-based
// reference model, plus directed latency, priority, duplicate-request and abort cases.
module tb_vram_arbiter;

    localparam int AC = 2;
    localparam int SL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_active, disp_req, disp_valid;
    logic [17:0] disp_addr, cpu_addr, sram_addr;
    logic [15:0] disp_rdata, cpu_wdata, cpu_rdata, sram_din, sram_dout;
    logic        cpu_req, cpu_we, cpu_done;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    vram_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .disp_active(disp_active),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_valid(disp_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model, aliased on the low 8 address bits
    logic [15:0] mem [0:255];
    always_comb sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_dout;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each grant at cycle g occupies g+1..g+AC and completes at g+AC+1
    logic [15:0] refMem [0:255];
    bit          pendD, pendC, capCW, inAcc, gD, gC, accD, accC;
    logic [17:0] capDA, capCA, curAddr;
    logic [15:0] capWd, curWd, expRdD, expRdC;
    int          accStart, accEnd, doneAt, freeAt, cur, waitCnt;
    int          doneCnt = 0, lastDone = -100, lastValid = -100, weLowCnt = 0;

    always @(negedge clk) begin
        if (cpu_done) begin doneCnt++; lastDone = cyc; end
        if (disp_valid) lastValid = cyc;
        if (!sram_we_n) weLowCnt++;
        if (!rst) begin
            pendD = 1'b0; pendC = 1'b0; waitCnt = 0; cur = 0;
            accStart = 1; accEnd = 0; doneAt = -1; freeAt = 0;
            expRdD = 16'h0000; expRdC = 16'h0000;
            for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
            checkEq("rst_ce_n", 32'(sram_ce_n), 32'd1);
            checkEq("rst_oe_n", 32'(sram_oe_n), 32'd1);
            checkEq("rst_we_n", 32'(sram_we_n), 32'd1);
            checkEq("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
            checkEq("rst_pulses", 32'({disp_valid, cpu_done}), 32'd0);
            checkEq("rst_rdata", {disp_rdata, cpu_rdata}, 32'd0);
        end else begin
            inAcc = (cyc >= accStart) && (cyc <= accEnd);
            if (cyc == doneAt) begin
                if (cur == 0) expRdD = refMem[curAddr[7:0]];
                else if (cur == 1) expRdC = refMem[curAddr[7:0]];
            end
            checkEq("ce_n", 32'(sram_ce_n), 32'(!inAcc));
            checkEq("oe_n", 32'(sram_oe_n), 32'(!(inAcc && cur != 2)));
            checkEq("we_n", 32'(sram_we_n), 32'(!(inAcc && cur == 2)));
            checkEq("dq_oe", 32'(sram_dq_oe), 32'(inAcc && cur == 2));
            if (inAcc) checkEq("sram_addr", 32'(sram_addr), 32'(curAddr));
            if (inAcc && cur == 2) checkEq("sram_dout", 32'(sram_dout), 32'(curWd));
            checkEq("disp_valid", 32'(disp_valid), 32'(cyc == doneAt && cur == 0));
            checkEq("cpu_done", 32'(cpu_done), 32'(cyc == doneAt && cur != 0));
            checkEq("disp_rdata", 32'(disp_rdata), 32'(expRdD));
            checkEq("cpu_rdata", 32'(cpu_rdata), 32'(expRdC));
            gD = 1'b0; gC = 1'b0;
            if (cyc >= freeAt) begin
                if (pendD && (!pendC || (disp_active && waitCnt < SL))) gD = 1'b1;
                else if (pendC) gC = 1'b1;
            end
            accD = disp_req && !pendD && !(inAcc && cur == 0);
            accC = cpu_req && !pendC && !(inAcc && cur != 0);
            if (gD) begin
                if (pendC && waitCnt < SL) waitCnt++;
                cur = 0; curAddr = capDA; pendD = 1'b0;
            end
            if (gC) begin
                waitCnt = 0; cur = capCW ? 2 : 1; curAddr = capCA; curWd = capWd; pendC = 1'b0;
                if (capCW) refMem[capCA[7:0]] = capWd;
            end
            if (gD || gC) begin
                accStart = cyc + 1; accEnd = cyc + AC; doneAt = cyc + AC + 1; freeAt = doneAt;
            end
            if (accD) begin pendD = 1'b1; capDA = disp_addr; end
            if (accC) begin pendC = 1'b1; capCA = cpu_addr; capCW = cpu_we; capWd = cpu_wdata; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int after);
        for (int i = 0; i < 40 && lastDone <= after; i++) tick();
    endtask

    int t0, w0, d0;

    initial begin
        disp_active = 1'b0; disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        disp_addr = 18'd0; cpu_addr = 18'd0; cpu_wdata = 16'd0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Uncontended write then read-back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00010; cpu_wdata = 16'hBEEF;
        t0 = cyc; w0 = weLowCnt;
        tick(); cpu_req = 1'b0;
        waitDone(t0);
        checkEq("wr_latency", 32'(lastDone - t0), 32'd4);
        checkEq("we_low_cycles", 32'(weLowCnt - w0), 32'd2);
        cpu_req = 1'b1; cpu_we = 1'b0;
        t0 = cyc;
        tick(); cpu_req = 1'b0;
        waitDone(t0);
        checkEq("rd_latency", 32'(lastDone - t0), 32'd4);
        checkEq("rd_beef", 32'(cpu_rdata), 32'h0000BEEF);
        repeat (2) tick();

        // Simultaneous requests, display priority
        disp_active = 1'b1; disp_req = 1'b1; disp_addr = 18'h00010; cpu_req = 1'b1;
        t0 = cyc;
        tick(); disp_req = 1'b0; cpu_req = 1'b0;
        waitDone(t0);
        checkEq("disp_first_valid", 32'(lastValid - t0), 32'd4);
        checkEq("disp_first_gap", 32'(lastDone - lastValid), 32'd3);
        repeat (2) tick();

        // Simultaneous requests, blanking: CPU first
        disp_active = 1'b0; disp_req = 1'b1; cpu_req = 1'b1; cpu_addr = 18'h00022;
        t0 = cyc;
        tick(); disp_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 40 && lastValid <= t0; i++) tick();
        checkEq("cpu_first_done", 32'(lastDone - t0), 32'd4);
        checkEq("cpu_first_gap", 32'(lastValid - lastDone), 32'd3);
        repeat (2) tick();

        // Duplicate CPU request while pending
        d0 = doneCnt;
        cpu_req = 1'b1; cpu_addr = 18'h00005;
        tick(); cpu_addr = 18'h00006;
        tick(); cpu_req = 1'b0;
        repeat (12) tick();
        checkEq("single_done", 32'(doneCnt - d0), 32'd1);

        // Display re-requests on every valid pulse while CPU waits
        disp_active = 1'b1; d0 = doneCnt;
        disp_req = 1'b1; cpu_req = 1'b1; cpu_addr = 18'h00033;
        tick(); cpu_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            disp_req = disp_valid;
            disp_addr = 18'($urandom);
            tick();
        end
        disp_req = 1'b0;
        repeat (6) tick();
        checkEq("starve_cpu_served", 32'(doneCnt - d0), 32'd1);

        // Reset during the second cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00020; cpu_wdata = 16'h1234;
        t0 = cyc;
        tick(); cpu_req = 1'b0;
        for (int i = 0; i < 10 && cyc < t0 + 3; i++) tick();
        d0 = doneCnt;
        #2 rst = 1'b0;
        #1;
        checkEq("abort_ce_n", 32'(sram_ce_n), 32'd1);
        checkEq("abort_we_n", 32'(sram_we_n), 32'd1);
        checkEq("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (8) tick();
        checkEq("abort_no_done", 32'(doneCnt - d0), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) disp_active = 1'($urandom_range(0, 1));
            disp_req  = ($urandom_range(0, 3) == 0);
            disp_addr = 18'($urandom);
            cpu_req   = ($urandom_range(0, 3) == 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 18'($urandom);
            cpu_wdata = 16'($urandom);
            tick();
        end
        disp_req = 1'b0; cpu_req = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
